// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, destination select, iterative
// shift-add multiplier, and the EX/MEM pipeline register.
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cache_stall,
    input  logic [1:0]       RegDst_i,
    input  logic [1:0]       CachetoReg_i,
    input  logic [3:0]       ALU_control_i,
    input  logic             CacheRead_i,
    input  logic             CacheWrite_i,
    input  logic             ALUSrc_i,
    input  logic             RegWrite_i,
    input  logic [WIDTH-1:0] read_data1_i,
    input  logic [WIDTH-1:0] read_data2_i,
    input  logic [WIDTH-1:0] SignExtImm_i,
    input  logic [WIDTH-1:0] incremented_PC_i,
    input  logic [4:0]       rs_i,
    input  logic [4:0]       rt_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       shamt_i,
    input  logic             WB_RegWrite_i,
    input  logic [4:0]       WB_rd_i,
    input  logic [WIDTH-1:0] WB_data_i,
    output logic             ex_busy,
    output logic [1:0]       CachetoReg_o,
    output logic             CacheRead_o,
    output logic             CacheWrite_o,
    output logic             RegWrite_o,
    output logic [WIDTH-1:0] ALU_result_o,
    output logic [WIDTH-1:0] write_data_o,
    output logic [4:0]       write_reg_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_LINK = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    mul_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] fwd_a, fwd_b, op_b, alu_res;
    logic [4:0]       write_reg;
    logic             is_mul;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [1:0]       c2r_q, c2r_d;
    logic             cread_q, cread_d;
    logic             cwrite_q, cwrite_d;
    logic             regwrite_q, regwrite_d;

    assign is_mul = (ALU_control_i == OP_MUL);

    // EX/MEM beats MEM/WB; register $0 is hard-wired and never forwarded.
    always_comb begin
        fwd_a = read_data1_i;
        if (regwrite_q && (wreg_q != 5'd0) && (wreg_q == rs_i)) begin
            fwd_a = result_q;
        end else if (WB_RegWrite_i && (WB_rd_i != 5'd0) && (WB_rd_i == rs_i)) begin
            fwd_a = WB_data_i;
        end

        fwd_b = read_data2_i;
        if (regwrite_q && (wreg_q != 5'd0) && (wreg_q == rt_i)) begin
            fwd_b = result_q;
        end else if (WB_RegWrite_i && (WB_rd_i != 5'd0) && (WB_rd_i == rt_i)) begin
            fwd_b = WB_data_i;
        end

        op_b = ALUSrc_i ? SignExtImm_i : fwd_b;
    end

    always_comb begin
        alu_res = '0;
        case (ALU_control_i)
            OP_AND:  alu_res = fwd_a & op_b;
            OP_OR:   alu_res = fwd_a | op_b;
            OP_ADD:  alu_res = fwd_a + op_b;
            OP_SUB:  alu_res = fwd_a - op_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            OP_NOR:  alu_res = ~(fwd_a | op_b);
            OP_SLL:  alu_res = op_b << shamt_i;
            OP_SRL:  alu_res = op_b >> shamt_i;
            OP_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt_i);
            OP_LINK: alu_res = incremented_PC_i;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        write_reg = 5'd0;
        case (RegDst_i)
            2'b00:   write_reg = rt_i;
            2'b01:   write_reg = rd_i;
            2'b10:   write_reg = 5'd31;
            default: write_reg = 5'd0;
        endcase
    end

    // Operands are captured on entry, so forwarding changes during BUSY are ignored.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    state_d  = BUSY;
                    mcand_d  = fwd_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    count_d  = CW'(WIDTH);
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (!cache_stall) begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign ex_busy = ((state_q == IDLE) && is_mul) || (state_q == BUSY);

    always_comb begin
        result_d   = alu_res;
        wdata_d    = fwd_b;
        wreg_d     = write_reg;
        c2r_d      = CachetoReg_i;
        cread_d    = CacheRead_i;
        cwrite_d   = CacheWrite_i;
        regwrite_d = RegWrite_i;
        if (ex_busy) begin
            result_d   = '0;
            wdata_d    = '0;
            wreg_d     = 5'd0;
            c2r_d      = 2'b00;
            cread_d    = 1'b0;
            cwrite_d   = 1'b0;
            regwrite_d = 1'b0;
        end else if (state_q == DONE) begin
            result_d = acc_q;
        end
    end

    // Cache stall freezes EX/MEM ahead of any bubble insertion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= '0;
            wdata_q    <= '0;
            wreg_q     <= 5'd0;
            c2r_q      <= 2'b00;
            cread_q    <= 1'b0;
            cwrite_q   <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (!cache_stall) begin
            result_q   <= result_d;
            wdata_q    <= wdata_d;
            wreg_q     <= wreg_d;
            c2r_q      <= c2r_d;
            cread_q    <= cread_d;
            cwrite_q   <= cwrite_d;
            regwrite_q <= regwrite_d;
        end
    end

    assign ALU_result_o = result_q;
    assign write_data_o = wdata_q;
    assign write_reg_o  = wreg_q;
    assign CachetoReg_o = c2r_q;
    assign CacheRead_o  = cread_q;
    assign CacheWrite_o = cwrite_q;
    assign RegWrite_o   = regwrite_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed vectors, multiplier corner cases, and
// randomized traffic checked against a behavioural pipeline model.
module tb_ex_stage;

    localparam int WIDTH = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_LINK = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        aluSrc;
        logic [4:0]  shamt;
        logic [1:0]  regDst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  c2r;
        logic        cr;
        logic        cw;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic [31:0] expRes;
        logic [4:0]  expWr;
    } vector_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        cacheStall;
    logic [1:0]  regDst;
    logic [1:0]  cacheToReg;
    logic [3:0]  aluControl;
    logic        cacheRead;
    logic        cacheWrite;
    logic        aluSrc;
    logic        regWrite;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] signExtImm;
    logic [31:0] incPc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic        wbRegWrite;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        exBusy;
    logic [1:0]  cacheToRegO;
    logic        cacheReadO;
    logic        cacheWriteO;
    logic        regWriteO;
    logic [31:0] aluResultO;
    logic [31:0] writeDataO;
    logic [4:0]  writeRegO;

    int nChecks = 0;
    int nFail   = 0;

    vector_t vecs[$];

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst_n            (rstN),
        .cache_stall      (cacheStall),
        .RegDst_i         (regDst),
        .CachetoReg_i     (cacheToReg),
        .ALU_control_i    (aluControl),
        .CacheRead_i      (cacheRead),
        .CacheWrite_i     (cacheWrite),
        .ALUSrc_i         (aluSrc),
        .RegWrite_i       (regWrite),
        .read_data1_i     (readData1),
        .read_data2_i     (readData2),
        .SignExtImm_i     (signExtImm),
        .incremented_PC_i (incPc),
        .rs_i             (rs),
        .rt_i             (rt),
        .rd_i             (rd),
        .shamt_i          (shamt),
        .WB_RegWrite_i    (wbRegWrite),
        .WB_rd_i          (wbRd),
        .WB_data_i        (wbData),
        .ex_busy          (exBusy),
        .CachetoReg_o     (cacheToRegO),
        .CacheRead_o      (cacheReadO),
        .CacheWrite_o     (cacheWriteO),
        .RegWrite_o       (regWriteO),
        .ALU_result_o     (aluResultO),
        .write_data_o     (writeDataO),
        .write_reg_o      (writeRegO)
    );

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [73:0] exmemBus();
        return {cacheToRegO, cacheReadO, cacheWriteO, regWriteO, writeRegO, aluResultO, writeDataO};
    endfunction

    function automatic instr_t mkInstr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] rsN, input logic [4:0] rtN, input logic [4:0] rdN,
                                       input logic [1:0] dst, input logic rw);
        instr_t i;
        i.op = op; i.a = a; i.b = b; i.imm = 32'd0; i.pc = 32'd0; i.aluSrc = 1'b0;
        i.shamt = 5'd0; i.regDst = dst; i.rs = rsN; i.rt = rtN; i.rd = rdN; i.rw = rw;
        i.c2r = 2'b00; i.cr = 1'b0; i.cw = 1'b0;
        return i;
    endfunction

    task automatic applyStimulus(input instr_t i);
        aluControl = i.op;   readData1  = i.a;    readData2 = i.b;
        signExtImm = i.imm;  incPc      = i.pc;   aluSrc    = i.aluSrc;
        shamt      = i.shamt; regDst    = i.regDst;
        rs = i.rs; rt = i.rt; rd = i.rd;
        regWrite = i.rw; cacheToReg = i.c2r; cacheRead = i.cr; cacheWrite = i.cw;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input instr_t i, input logic [31:0] res, input logic [4:0] wr);
        vector_t v;
        v.in = i; v.expRes = res; v.expWr = wr;
        vecs.push_back(v);
    endtask

    // Drives one MUL (rs=5, rt=6, rd=9) and follows it until the product lands.
    task automatic runMul(input logic [31:0] a, input logic [31:0] b, input int stallAt, input int stallLen,
                          input logic [31:0] expProd, input string tag);
        int  busyCycles = 0;
        int  cyc = 0;
        bit  done = 0;
        applyStimulus(mkInstr(OP_MUL, a, b, 5'd5, 5'd6, 5'd9, 2'b01, 1'b1));
        wbRegWrite = 1'b0;
        cacheStall = 1'b0;
        while (!done && cyc < 200) begin
            cacheStall = (stallAt >= 0) && (cyc >= stallAt) && (cyc < stallAt + stallLen);
            if (cyc > 0) begin
                wbRegWrite = 1'b1;
                wbRd       = 5'd5;
                wbData     = $urandom;
            end
            #2;
            if (exBusy) busyCycles++;
            if (cyc > 0) checkOutput({tag, ".bubble"}, 80'(exmemBus()), 80'(0));
            if (cyc > 0 && !exBusy) done = 1;
            nextCycle();
            cyc++;
        end
        checkOutput({tag, ".timeout"}, 80'(done), 80'(1));
        checkOutput({tag, ".busyCycles"}, 80'(busyCycles), 80'(WIDTH + 1 + stallLen));
        checkOutput({tag, ".product"}, 80'(aluResultO), 80'(expProd));
        checkOutput({tag, ".ctrl"}, 80'({regWriteO, writeRegO}), 80'({1'b1, 5'd9}));
        wbRegWrite = 1'b0;
        cacheStall = 1'b0;
    endtask

    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh, input logic [31:0] pc);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_NOR:  return ~(a | b);
            OP_SLL:  return b << sh;
            OP_SRL:  return b >> sh;
            OP_SRA:  return $unsigned($signed(b) >>> sh);
            OP_LINK: return pc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic randomPhase(input int cycles);
        logic [31:0] mRes = 0, mWd = 0, mProd = 0;
        logic [4:0]  mWr = 0;
        logic        mRW = 0, mRead = 0, mWrite = 0;
        logic [1:0]  mC2R = 0;
        bit          mulActive = 0;
        int          mulLeft = 0;
        bit          hold = 0;
        logic [31:0] fA, fB, oB;
        logic [4:0]  wsel;
        logic        expBusy;
        instr_t      ri;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            if (!hold) begin
                ri = mkInstr(4'($urandom_range(0, 15)),
                             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
                             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                ri.imm = $urandom; ri.pc = $urandom; ri.aluSrc = 1'($urandom_range(0, 1));
                ri.shamt = 5'($urandom_range(0, 31)); ri.c2r = 2'($urandom_range(0, 3));
                ri.cr = 1'($urandom_range(0, 1)); ri.cw = 1'($urandom_range(0, 1));
                applyStimulus(ri);
            end
            wbRegWrite = 1'($urandom_range(0, 1));
            wbRd       = 5'($urandom_range(0, 3));
            wbData     = $urandom;
            cacheStall = ($urandom_range(0, 9) == 0);
            #2;
            fA = (mRW && mWr != 0 && mWr == rs) ? mRes : (wbRegWrite && wbRd != 0 && wbRd == rs) ? wbData : readData1;
            fB = (mRW && mWr != 0 && mWr == rt) ? mRes : (wbRegWrite && wbRd != 0 && wbRd == rt) ? wbData : readData2;
            oB = aluSrc ? signExtImm : fB;
            wsel = (regDst == 2'd0) ? rt : (regDst == 2'd1) ? rd : (regDst == 2'd2) ? 5'd31 : 5'd0;
            expBusy = mulActive ? (mulLeft > 0) : (aluControl == OP_MUL);
            checkOutput("rnd.busy", 80'(exBusy), 80'(expBusy));
            checkOutput("rnd.exmem", 80'(exmemBus()), 80'({mC2R, mRead, mWrite, mRW, mWr, mRes, mWd}));
            if (!cacheStall) begin
                if (expBusy) begin
                    if (mulActive) begin
                        mulLeft--;
                    end else begin
                        mulActive = 1;
                        mulLeft   = WIDTH;
                        mProd     = 32'(64'(fA) * 64'(oB));
                    end
                    {mC2R, mRead, mWrite, mRW, mWr, mRes, mWd} = '0;
                end else begin
                    mRes = mulActive ? mProd : refAlu(aluControl, fA, oB, shamt, incPc);
                    mulActive = 0;
                    {mC2R, mRead, mWrite, mRW, mWr, mWd} = {cacheToReg, cacheRead, cacheWrite, regWrite, wsel, fB};
                end
            end
            hold = expBusy || cacheStall;
            nextCycle();
        end
    endtask

    initial begin
        instr_t ti;
        rstN = 1'b0; cacheStall = 1'b0;
        applyStimulus(mkInstr(OP_NOP, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0));
        wbRegWrite = 1'b0; wbRd = 5'd0; wbData = 32'd0;

        // Table of single-cycle ALU operations; rs=1, rt=2 are never written by the table.
        addVec(mkInstr(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 2, 3, 2'b01, 1), 32'h0F00_0F00, 5'd3);
        addVec(mkInstr(OP_OR,  32'hFF00_FF00, 32'h0F0F_0F0F, 1, 2, 3, 2'b01, 1), 32'hFF0F_FF0F, 5'd3);
        addVec(mkInstr(OP_ADD, 32'hFFFF_FFFF, 32'd2,         1, 2, 3, 2'b01, 1), 32'd1,         5'd3);
        addVec(mkInstr(OP_SUB, 32'd3,         32'd5,         1, 2, 3, 2'b01, 1), 32'hFFFF_FFFE, 5'd3);
        addVec(mkInstr(OP_SLT, 32'hFFFF_FFFF, 32'd1,         1, 2, 3, 2'b01, 1), 32'd1,         5'd3);
        addVec(mkInstr(OP_SLT, 32'd1,         32'hFFFF_FFFF, 1, 2, 3, 2'b01, 1), 32'd0,         5'd3);
        addVec(mkInstr(OP_NOR, 32'hF0F0_0000, 32'h0000_F0F0, 1, 2, 3, 2'b01, 1), 32'h0F0F_0F0F, 5'd3);
        ti = mkInstr(OP_SLL, 32'd0, 32'h8000_0001, 1, 2, 3, 2'b01, 1); ti.shamt = 5'd4;
        addVec(ti, 32'h0000_0010, 5'd3);
        ti = mkInstr(OP_SRL, 32'd0, 32'h8000_0010, 1, 2, 3, 2'b01, 1); ti.shamt = 5'd4;
        addVec(ti, 32'h0800_0001, 5'd3);
        ti = mkInstr(OP_SRA, 32'd0, 32'h8000_0010, 1, 2, 3, 2'b01, 1); ti.shamt = 5'd4;
        addVec(ti, 32'hF800_0001, 5'd3);
        ti = mkInstr(OP_LINK, 32'd7, 32'd8, 1, 2, 3, 2'b10, 1); ti.pc = 32'h1234;
        addVec(ti, 32'h1234, 5'd31);
        addVec(mkInstr(OP_NOP, 32'd7, 32'd8, 1, 2, 3, 2'b01, 1), 32'd0, 5'd3);
        addVec(mkInstr(4'b1010, 32'd7, 32'd8, 1, 2, 3, 2'b01, 1), 32'd0, 5'd3);
        ti = mkInstr(OP_ADD, 32'h10, 32'h777, 1, 2, 3, 2'b11, 1); ti.aluSrc = 1'b1; ti.imm = 32'hFFFF_FFFC;
        addVec(ti, 32'h0000_000C, 5'd0);
        addVec(mkInstr(OP_OR, 32'd1, 32'd2, 1, 2, 3, 2'b00, 0), 32'd3, 5'd2);

        repeat (2) nextCycle();
        checkOutput("reset.exmem", 80'(exmemBus()), 80'(0));
        checkOutput("reset.busy", 80'(exBusy), 80'(0));
        rstN = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            vector_t v;
            logic [3:0] kb;
            v  = vecs[k];
            kb = 4'(k);
            v.in.c2r = kb[1:0]; v.in.cr = kb[2]; v.in.cw = kb[3];
            applyStimulus(v.in);
            #2;
            checkOutput($sformatf("vec%0d.busy", k), 80'(exBusy), 80'(0));
            nextCycle();
            checkOutput($sformatf("vec%0d.result", k), 80'(aluResultO), 80'(v.expRes));
            checkOutput($sformatf("vec%0d.writeReg", k), 80'(writeRegO), 80'(v.expWr));
            checkOutput($sformatf("vec%0d.writeData", k), 80'(writeDataO), 80'(v.in.b));
            checkOutput($sformatf("vec%0d.ctrl", k), 80'({regWriteO, cacheToRegO, cacheReadO, cacheWriteO}),
                        80'({v.in.rw, kb[1:0], kb[2], kb[3]}));
        end

        // Reset in the middle of a multiply, with count at 10.
        applyStimulus(mkInstr(OP_MUL, 32'd1234, 32'd5678, 5'd5, 5'd6, 5'd9, 2'b01, 1'b1));
        #2;
        checkOutput("t1.busyOnIssue", 80'(exBusy), 80'(1));
        nextCycle();
        repeat (22) @(posedge clk);
        #1;
        checkOutput("t1.busyMid", 80'(exBusy), 80'(1));
        rstN = 1'b0;
        aluControl = OP_NOP;
        nextCycle();
        checkOutput("t1.exmemReset", 80'(exmemBus()), 80'(0));
        checkOutput("t1.busyReset", 80'(exBusy), 80'(0));
        rstN = 1'b1;
        applyStimulus(mkInstr(OP_ADD, 32'd2, 32'd3, 5'd4, 5'd5, 5'd1, 2'b01, 1'b1));
        #2;
        checkOutput("t1.idleAfterReset", 80'(exBusy), 80'(0));
        nextCycle();
        checkOutput("t1.addAfterReset", 80'({writeRegO, aluResultO}), 80'({5'd1, 32'd5}));

        // $1=5 sits in EX/MEM while MEM/WB also offers $1=9.
        applyStimulus(mkInstr(OP_ADD, 32'h77, 32'd7, 5'd1, 5'd2, 5'd3, 2'b01, 1'b1));
        wbRegWrite = 1'b1; wbRd = 5'd1; wbData = 32'd9;
        nextCycle();
        checkOutput("t2.exmemPriority", 80'(aluResultO), 80'(32'd12));

        ti = mkInstr(OP_ADD, 32'h100, 32'h1111, 5'd4, 5'd8, 5'd0, 2'b00, 1'b0);
        ti.aluSrc = 1'b1; ti.imm = 32'd4; ti.cw = 1'b1;
        applyStimulus(ti);
        wbRegWrite = 1'b1; wbRd = 5'd8; wbData = 32'hDEAD;
        nextCycle();
        checkOutput("t3.address", 80'(aluResultO), 80'(32'h104));
        checkOutput("t3.storeData", 80'(writeDataO), 80'(32'hDEAD));
        checkOutput("t3.ctrl", 80'({cacheWriteO, regWriteO}), 80'(2'b10));
        wbRegWrite = 1'b0;

        runMul(32'hFFFF_FFFF, 32'd3, -1, 0, 32'hFFFF_FFFD, "t4");
        runMul(32'd7, 32'd6, 5, 5, 32'd42, "t5");
        runMul(32'h0001_0001, 32'h0001_0001, -1, 0, 32'h0002_0001, "t5b2b");

        ti = mkInstr(OP_LINK, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b1);
        ti.pc = 32'h40;
        applyStimulus(ti);
        nextCycle();
        checkOutput("t6.jal", 80'({writeRegO, aluResultO}), 80'({5'd31, 32'h40}));
        applyStimulus(mkInstr(OP_ADD, 32'd0, 32'd1, 5'd31, 5'd2, 5'd3, 2'b01, 1'b1));
        nextCycle();
        checkOutput("t6.readRa", 80'(aluResultO), 80'(32'h41));

        // A cache stall holds EX/MEM on an ordinary ALU op.
        applyStimulus(mkInstr(OP_OR, 32'hF0, 32'h0F, 5'd4, 5'd5, 5'd3, 2'b01, 1'b1));
        cacheStall = 1'b1;
        nextCycle();
        checkOutput("stall.hold", 80'(aluResultO), 80'(32'h41));
        cacheStall = 1'b0;
        nextCycle();
        checkOutput("stall.release", 80'(aluResultO), 80'(32'hFF));

        // Writes to $0 from either stage must not be forwarded.
        applyStimulus(mkInstr(OP_ADD, 32'h50, 32'd5, 5'd4, 5'd5, 5'd3, 2'b11, 1'b1));
        nextCycle();
        checkOutput("zero.dst", 80'({writeRegO, regWriteO, aluResultO}), 80'({5'd0, 1'b1, 32'h55}));
        applyStimulus(mkInstr(OP_ADD, 32'd0, 32'd1, 5'd0, 5'd5, 5'd3, 2'b01, 1'b1));
        wbRegWrite = 1'b1; wbRd = 5'd0; wbData = 32'h99;
        nextCycle();
        checkOutput("zero.noForward", 80'(aluResultO), 80'(32'd1));
        wbRegWrite = 1'b0;

        rstN = 1'b0;
        nextCycle();
        rstN = 1'b1;
        randomPhase(600);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", nChecks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
